// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Fetch program-counter sequencer with branch/jump redirect and a fetch
//   flush window. In RUN the PC advances by 4 per cycle unless stalled.
//   A taken conditional branch or an unconditional jump redirects the PC and
//   enters FLUSH. FLUSH lasts FLUSH_CYCLES cycles. Branch and jump requests
//   seen during FLUSH belong to squashed instructions and are ignored.
//
// Parameters:
//   DWIDTH       datapath / PC width in bits
//   RESET_PC     PC value loaded while nReset is low
//   FLUSH_CYCLES flush pulse length in cycles (1..7)
//
// Ports:
//   clk         in   rising-edge clock
//   nReset      in   asynchronous active-low reset
//   stall       in   hold PC (no sequential advance)
//   br_valid    in   conditional branch present in execute
//   brfunc[2:0] in   branch funct3 code
//   A, B        in   branch operands
//   br_target   in   branch target address
//   jmp_valid   in   unconditional jump present in execute (wins over branch)
//   jmp_target  in   jump target address
//   pc          out  current fetch address (registered)
//   flush       out  squash fetch/decode, high while in FLUSH (registered)
//   taken       out  one-cycle pulse: redirect accepted on the last edge
//   illegal_br  out  one-cycle pulse: br_valid with brfunc 010/011 in RUN
//   misalign    out  one-cycle pulse: redirect target had bits [1:0] != 0
//
// Optional feature (macro PC_SEQUENCER_PERF_EN):
//   br_count    out  saturating count of branches evaluated in RUN
//   taken_count out  saturating count of accepted conditional branches
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                 DWIDTH       = 32,
  parameter logic [DWIDTH-1:0]  RESET_PC     = '0,
  parameter int                 FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [2:0]        brfunc,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  input  logic [DWIDTH-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [DWIDTH-1:0] jmp_target,
  output logic [DWIDTH-1:0] pc,
  output logic              flush,
  output logic              taken,
  output logic              illegal_br,
  output logic              misalign
`ifdef PC_SEQUENCER_PERF_EN
  ,
  output logic [31:0]       br_count,
  output logic [31:0]       taken_count
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0]        FLUSH_LEN = 3'(FLUSH_CYCLES);
  localparam logic [DWIDTH-1:0] PC_STEP   = DWIDTH'(4);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [DWIDTH-1:0] r_pc, w_pc_nxt;
  logic              r_flush, r_taken, r_illegal, r_misalign;
  logic              w_taken_nxt, w_illegal_nxt, w_misalign_nxt;

  logic              w_br_true;     // branch condition holds
  logic              w_br_illegal;  // reserved funct3 code
  logic              w_redirect;
  logic [DWIDTH-1:0] w_target;

  // Branch condition evaluation; reserved codes never take.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_br_true    = 1'b0;
    w_br_illegal = 1'b0;
    case (brfunc)
      3'b000:  w_br_true = (A == B);
      3'b001:  w_br_true = (A != B);
      3'b100:  w_br_true = ($signed(A) <  $signed(B));
      3'b101:  w_br_true = ($signed(A) >= $signed(B));
      3'b110:  w_br_true = (A <  B);
      3'b111:  w_br_true = (A >= B);
      default: w_br_illegal = 1'b1;
    endcase
  end

  // Jump wins when both are present in the same cycle.
  assign w_redirect = jmp_valid | (br_valid & w_br_true);
  assign w_target   = jmp_valid ? jmp_target : br_target;

  // Next-state / next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_nxt       = stall ? r_pc : r_pc + PC_STEP;  // wraps modulo 2^DWIDTH
    w_taken_nxt    = 1'b0;
    w_illegal_nxt  = 1'b0;
    w_misalign_nxt = 1'b0;
    case (r_state)
      RUN: begin
        w_illegal_nxt = br_valid & w_br_illegal;
        if (w_redirect) begin
          // Redirect overrides stall; target is word-aligned by force.
          w_pc_nxt       = {w_target[DWIDTH-1:2], 2'b00};
          w_state_nxt    = FLUSH;
          w_cnt_nxt      = FLUSH_LEN;
          w_taken_nxt    = 1'b1;
          w_misalign_nxt = |w_target[1:0];
        end
      end
      FLUSH: begin
        // Counter runs regardless of stall; requests here are squashed.
        if (r_cnt <= 3'd1) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= RUN;
      r_cnt      <= 3'd0;
      r_pc       <= RESET_PC;
      r_flush    <= 1'b0;
      r_taken    <= 1'b0;
      r_illegal  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_flush    <= (w_state_nxt == FLUSH);
      r_taken    <= w_taken_nxt;
      r_illegal  <= w_illegal_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign pc         = r_pc;
  assign flush      = r_flush;
  assign taken      = r_taken;
  assign illegal_br = r_illegal;
  assign misalign   = r_misalign;

`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] r_br_count, r_taken_count;
  logic        w_br_eval, w_br_accept;

  // Only branches seen in RUN count; a branch losing to a jump is evaluated
  // but not accepted.
  assign w_br_eval   = (r_state == RUN) & br_valid;
  assign w_br_accept = w_br_eval & ~jmp_valid & w_br_true;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      if (w_br_eval && (r_br_count != '1))
        r_br_count <= r_br_count + 32'd1;
      if (w_br_accept && (r_taken_count != '1))
        r_taken_count <= r_taken_count + 32'd1;
    end
  end

  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer (default parameters, default build).
// Each step drives inputs, pushes the expected post-edge outputs into a
// scoreboard queue, then pops and compares after the rising edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        taken;
    logic        ill;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        nReset;
  logic        stall;
  logic        br_valid;
  logic [2:0]  brfunc;
  logic [31:0] A, B, br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic [31:0] pc;
  logic        flush, taken, illegal_br, misalign;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  pc_sequencer dut (
    .clk        (clk),
    .nReset     (nReset),
    .stall      (stall),
    .br_valid   (br_valid),
    .brfunc     (brfunc),
    .A          (A),
    .B          (B),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .pc         (pc),
    .flush      (flush),
    .taken      (taken),
    .illegal_br (illegal_br),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input exp_t e);
    check({e.tag, ".pc"},         pc,                 e.pc);
    check({e.tag, ".flush"},      {31'd0, flush},      {31'd0, e.flush});
    check({e.tag, ".taken"},      {31'd0, taken},      {31'd0, e.taken});
    check({e.tag, ".illegal_br"}, {31'd0, illegal_br}, {31'd0, e.ill});
    check({e.tag, ".misalign"},   {31'd0, misalign},   {31'd0, e.mis});
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_valid = 1'b0; brfunc = 3'b000; A = '0; B = '0;
    br_target = '0; jmp_valid = 1'b0; jmp_target = '0;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string tag, input logic st,
                      input logic bv, input logic [2:0] bf,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] bt,
                      input logic jv, input logic [31:0] jt,
                      input logic [31:0] e_pc, input logic e_fl, input logic e_tk,
                      input logic e_il, input logic e_mi);
    exp_t e, got_e;
    stall = st; br_valid = bv; brfunc = bf; A = a; B = b; br_target = bt;
    jmp_valid = jv; jmp_target = jt;
    e.tag = tag; e.pc = e_pc; e.flush = e_fl; e.taken = e_tk; e.ill = e_il; e.mis = e_mi;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    compare_all(got_e);
  endtask

  task automatic idle(input string tag, input logic st, input logic [31:0] e_pc, input logic e_fl);
    step(tag, st, 1'b0, 3'b000, '0, '0, '0, 1'b0, '0, e_pc, e_fl, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t r;
    idle_inputs();
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    r.tag = "reset"; r.pc = 32'h0; r.flush = 0; r.taken = 0; r.ill = 0; r.mis = 0;
    compare_all(r);
    nReset = 1'b1;

    // Sequential fetch from RESET_PC.
    idle("seq1", 0, 32'h4,  0);
    idle("seq2", 0, 32'h8,  0);
    idle("seq3", 0, 32'hC,  0);
    idle("seq4", 0, 32'h10, 0);

    // Signed less-than taken: -1 < 1.
    step("blt_taken", 0, 1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h40, 0, '0,
         32'h40, 1, 1, 0, 0);
    idle("flush_a1", 0, 32'h44, 1);
    idle("flush_a2", 0, 32'h48, 0);

    // Unsigned less-than not taken: 0xFFFFFFFF < 1 is false.
    step("bltu_nt", 0, 1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h80, 0, '0,
         32'h4C, 0, 0, 0, 0);

    // Jump and branch together: jump target wins.
    step("jmp_wins", 0, 1, 3'b000, 32'h5, 32'h5, 32'h200, 1, 32'h100,
         32'h100, 1, 1, 0, 0);
    // True branch during FLUSH is ignored.
    step("flush_br_ign", 0, 1, 3'b001, 32'h1, 32'h2, 32'h300, 0, '0,
         32'h104, 1, 0, 0, 0);
    // Jump plus reserved code during FLUSH: no redirect, no illegal pulse.
    step("flush_jmp_ign", 0, 1, 3'b010, '0, '0, 32'h500, 1, 32'h400,
         32'h108, 0, 0, 0, 0);
    // Reserved code in RUN: illegal pulse, sequential advance.
    step("illegal_010", 0, 1, 3'b010, '0, '0, 32'h500, 0, '0,
         32'h10C, 0, 0, 1, 0);
    idle("illegal_clr", 0, 32'h110, 0);

    // Signed >= taken on equal negatives, then stall through FLUSH.
    step("bge_taken", 0, 1, 3'b101, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h20, 0, '0,
         32'h20, 1, 1, 0, 0);
    idle("flush_stall1", 1, 32'h20, 1);
    idle("flush_stall2", 1, 32'h20, 0);
    idle("run_stall",    1, 32'h20, 0);

    // Misaligned jump under stall: redirect still happens, low bits cleared.
    step("jmp_misalign", 1, 0, 3'b000, '0, '0, '0, 1, 32'h103,
         32'h100, 1, 1, 0, 1);
    idle("flush_b1", 0, 32'h104, 1);

    // Reset mid-FLUSH takes effect without a clock edge.
    nReset = 1'b0;
    #1;
    r.tag = "reset_mid_flush"; r.pc = 32'h0; r.flush = 0; r.taken = 0; r.ill = 0; r.mis = 0;
    compare_all(r);
    @(posedge clk);
    #1;
    nReset = 1'b1;
    idle("post_reset1", 0, 32'h4, 0);
    idle("post_reset2", 0, 32'h8, 0);

    // Wrap: jump to all-ones-minus-3, next PC is 0.
    step("jmp_top", 0, 0, 3'b000, '0, '0, '0, 1, 32'hFFFF_FFFC,
         32'hFFFF_FFFC, 1, 1, 0, 0);
    idle("wrap0", 0, 32'h0, 1);
    idle("wrap1", 0, 32'h4, 0);

    // Unsigned >= taken; unsigned < taken with misaligned target.
    step("bgeu_taken", 0, 1, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h60, 0, '0,
         32'h60, 1, 1, 0, 0);
    idle("flush_c1", 0, 32'h64, 1);
    idle("flush_c2", 0, 32'h68, 0);
    step("bltu_mis", 0, 1, 3'b110, 32'h1, 32'hFFFF_FFFF, 32'h61, 0, '0,
         32'h60, 1, 1, 0, 1);
    idle("flush_d1", 0, 32'h64, 1);
    idle("flush_d2", 0, 32'h68, 0);
    // Signed < false (1 < -1) and beq false: plain advance.
    step("blt_nt", 0, 1, 3'b100, 32'h1, 32'hFFFF_FFFF, 32'h90, 0, '0,
         32'h6C, 0, 0, 0, 0);
    step("beq_nt", 0, 1, 3'b000, 32'h1, 32'h2, 32'h90, 0, '0,
         32'h70, 0, 0, 0, 0);
    step("illegal_011", 0, 1, 3'b011, '0, '0, 32'h90, 0, '0,
         32'h74, 0, 0, 1, 0);

    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: DWIDTH, 32, datapath and PC width in bits.
REQ-002 Parameter: RESET_PC, 0, PC value loaded on reset.
REQ-003 Parameter: FLUSH_CYCLES, 2, flush pulse length in cycles, range 1..7.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: nReset  in  1  asynchronous, active-low reset.
REQ-006 Port: stall  in  1  hold PC; no sequential advance.
REQ-007 Port: br_valid  in  1  conditional branch present in execute this cycle.
REQ-008 Port: brfunc  in  3  branch funct3 code.
REQ-009 Port: A, B  in  DWIDTH each  branch operands, signed view.
REQ-010 Port: br_target  in  DWIDTH  branch target address.
REQ-011 Port: jmp_valid  in  1  unconditional jump (jal/jalr) present in execute.
REQ-012 Port: jmp_target  in  DWIDTH  jump target address.
REQ-013 Port: pc  out  DWIDTH  current fetch address, registered.
REQ-014 Port: flush  out  1  squash fetch/decode contents, registered.
REQ-015 Port: taken  out  1  one-cycle pulse: redirect accepted last edge.
REQ-016 Port: illegal_br  out  1  one-cycle pulse: br_valid with brfunc 010 or 011.
REQ-017 Port: misalign  out  1  one-cycle pulse: redirect target bits [1:0] non-zero.

Function
REQ-018 States: RUN and FLUSH; a counter holds the remaining flush cycles.
REQ-019 Comparisons: 000 A==B, 001 A!=B, 100 signed A<B, 101 signed A>=B, 110 unsigned A<B, 111 unsigned A>=B.
REQ-020 Codes 010/011 with br_valid: branch not taken; illegal_br pulses next cycle.
REQ-021 In RUN, a redirect is jmp_valid, or br_valid with a true comparison.
REQ-022 When jmp_valid and br_valid are both high, the jump wins and jmp_target is used.
REQ-023 On redirect: pc <= target with bits [1:0] forced to 0, regardless of stall.
REQ-024 On redirect: state <= FLUSH, counter <= FLUSH_CYCLES, taken pulses one cycle.
REQ-025 On redirect with target[1:0] != 0: misalign pulses in the same cycle as taken.
REQ-026 Without a redirect: pc <= pc+4 when stall is low and holds when stall is high.
REQ-027 pc+4 wraps modulo 2^DWIDTH; all-ones-minus-3 goes to 0.
REQ-028 flush is high exactly while state is FLUSH: FLUSH_CYCLES consecutive cycles starting the cycle after the redirect edge.
REQ-029 In FLUSH, br_valid and jmp_valid are ignored (squashed instructions): no redirect, no illegal_br.
REQ-030 In FLUSH, the counter decrements every cycle independent of stall; pc follows REQ-026.
REQ-031 At counter 1, state returns to RUN on the next edge; back-to-back redirects are evaluated only from RUN.

Reset
REQ-032 While nReset is low, the block asynchronously sets pc=RESET_PC, state=RUN, counter=0, and flush=taken=illegal_br=misalign=0.
REQ-033 Reset asserted mid-FLUSH aborts the flush immediately; after release the block fetches sequentially from RESET_PC.
REQ-034 The first edge after reset release either advances pc or redirects it per REQ-021 to REQ-026.

Configuration
REQ-035 Macro PC_SEQUENCER_PERF_EN: when defined, adds 32-bit outputs br_count and taken_count.
REQ-036 With the macro defined, br_count increments for every br_valid evaluated in RUN, and taken_count increments for every accepted conditional branch.
REQ-037 Both counters reset to 0, saturate at all-ones, and ignore jumps.
REQ-038 Without the macro, the counter ports and logic are absent and the rest of the behaviour is identical.

Verification
REQ-039 Reset release with no events, stall=0 -> pc 0,4,8,12 on successive edges; flush=0.
REQ-040 At pc=0x10, br_valid, brfunc=100, A=-1, B=1, br_target=0x40 -> pc=0x40, taken=1 for 1 cycle; flush=1 for 2 cycles; pc=0x44 then 0x48.
REQ-041 brfunc=110, A=-1 (0xFFFFFFFF), B=1 -> not taken; pc+4, flush stays 0.
REQ-042 jmp_valid and br_valid both high in one cycle, jmp_target=0x100, br_target=0x200 -> pc=0x100.
REQ-043 Further br_valid with a true condition during FLUSH -> ignored; br_valid brfunc=010 in RUN -> illegal_br=1 for 1 cycle, pc+4.
REQ-044 jmp_target=0x103 with stall=1 -> pc=0x100 and misalign=1; nReset pulsed low mid-FLUSH -> pc=RESET_PC and flush=0 at once.
